// File: rtl/cmd_reg_master_if.sv
// Bus bundle for cmd_reg_master: command FIFO read side, response FIFO
// write side and the register endpoint access port.
interface cmd_reg_master_if;
  // Command FIFO (show-ahead): head word plus empty flag, popped by cmd_rdreq.
  logic [31:0] cmd_data;
  logic        cmd_empty;
  logic        cmd_rdreq;

  // Response FIFO: one word pushed per rsp_wrreq.
  logic [31:0] rsp_data;
  logic        rsp_wrreq;
  logic        rsp_full;

  // Register endpoint: reg_enable[1] = access active, reg_enable[0] = read.
  logic [1:0]  reg_enable;
  logic [6:0]  reg_addr;
  logic [31:0] reg_dataout;
  logic [31:0] reg_datain;

  // Initiator view (cmd_reg_master).
  modport master (
    input  cmd_data, cmd_empty, rsp_full, reg_datain,
    output cmd_rdreq, rsp_data, rsp_wrreq, reg_enable, reg_addr, reg_dataout
  );

  // Environment view (FIFOs and register endpoint).
  modport slave (
    output cmd_data, cmd_empty, rsp_full, reg_datain,
    input  cmd_rdreq, rsp_data, rsp_wrreq, reg_enable, reg_addr, reg_dataout
  );
endinterface

// File: rtl/cmd_reg_master.sv
// Register-bus initiator. Pops WRITE/READ/PING commands from a show-ahead
// FIFO, performs the register access and pushes read/ping replies into a
// response FIFO. Commands are processed strictly one at a time.
module cmd_reg_master #(
  parameter int unsigned RD_LAT = 1  // read strobe cycles before sampling, 1..15
) (
  input  logic              clk,
  input  logic              reset,   // synchronous, active low
  cmd_reg_master_if.master  bus,
  output logic              busy,
  output logic [7:0]        err_count
);

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] OP_PING  = 8'h03;
  localparam logic [7:0] RSP_READ = 8'h82;
  localparam logic [7:0] RSP_PING = 8'h83;
  localparam logic [3:0] LAT_LAST = 4'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE, WDATA, WRITE, READ, RSP_HDR, RSP_DATA, PING
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  rid_q;
  logic [6:0]  addr_q;
  logic [31:0] data_q;
  logic [31:0] rd_data_q;
  logic [3:0]  lat_cnt;
  logic [1:0]  enable_q;

  logic hdr_load;
  logic data_load;
  logic rd_done;
  logic err_inc;

  // Next-state decode plus the combinational FIFO handshakes and reply word.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    bus.cmd_rdreq = 1'b0;
    bus.rsp_wrreq = 1'b0;
    bus.rsp_data  = '0;
    hdr_load      = 1'b0;
    data_load     = 1'b0;
    rd_done       = 1'b0;
    err_inc       = 1'b0;

    // While reset is held no FIFO is touched; the registers clear at the edge.
    if (reset) begin
      case (state_q)
        IDLE: begin
          if (!bus.cmd_empty) begin
            bus.cmd_rdreq = 1'b1;
            hdr_load      = 1'b1;
            case (bus.cmd_data[31:24])
              OP_WRITE: state_d = WDATA;
              OP_READ:  state_d = READ;
              OP_PING:  state_d = PING;
              default:  err_inc = 1'b1;   // unknown opcode: drop the word
            endcase
          end
        end
        WDATA: begin
          if (!bus.cmd_empty) begin
            bus.cmd_rdreq = 1'b1;
            data_load     = 1'b1;
            state_d       = WRITE;
          end
        end
        WRITE: state_d = IDLE;
        READ: begin
          if (lat_cnt == LAT_LAST) begin
            rd_done = 1'b1;
            state_d = RSP_HDR;
          end
        end
        RSP_HDR: begin
          bus.rsp_data = {RSP_READ, rid_q, 9'd0, addr_q};
          if (!bus.rsp_full) begin
            bus.rsp_wrreq = 1'b1;
            state_d       = RSP_DATA;
          end
        end
        RSP_DATA: begin
          bus.rsp_data = rd_data_q;
          if (!bus.rsp_full) begin
            bus.rsp_wrreq = 1'b1;
            state_d       = IDLE;
          end
        end
        PING: begin
          bus.rsp_data = {RSP_PING, rid_q, 16'd0};
          if (!bus.rsp_full) begin
            bus.rsp_wrreq = 1'b1;
            state_d       = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // that existed before this edge, independent of statement order.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Command fields, read data, latency counter, registered strobe and error count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rid_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rd_data_q <= '0;
      lat_cnt   <= '0;
      enable_q  <= 2'b00;
      err_count <= '0;
    end else begin
      if (hdr_load) begin
        rid_q  <= bus.cmd_data[23:16];
        addr_q <= bus.cmd_data[6:0];
      end
      if (data_load) data_q <= bus.cmd_data;
      if (rd_done)   rd_data_q <= bus.reg_datain;

      // Counts cycles spent in READ; zero on entry.
      lat_cnt <= (state_q == READ) ? lat_cnt + 4'd1 : 4'd0;

      // Strobe follows the state being entered so it lines up with that state.
      case (state_d)
        WRITE:   enable_q <= 2'b10;
        READ:    enable_q <= 2'b11;
        default: enable_q <= 2'b00;
      endcase

      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  assign bus.reg_enable  = enable_q;
  assign bus.reg_addr    = addr_q;
  assign bus.reg_dataout = data_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_cmd_reg_master.sv
// Testbench for cmd_reg_master: a queue models the command FIFO, expected
// responses and register writes go into scoreboards, and independent
// monitors compare whatever the DUT presents on the response FIFO and the
// register bus.
module tb_cmd_reg_master;

  localparam int RD_LAT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       busy;
  logic [7:0] err_count;

  cmd_reg_master_if bus ();

  cmd_reg_master #(.RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.master),
    .busy      (busy),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] cmd_q[$];     // command FIFO contents, head at index 0
  logic [31:0] exp_rsp[$];   // expected response words in order
  logic [38:0] exp_wr[$];    // expected writes {addr, data}
  int          exp_reads = 0;
  int          pops = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Advance n clock edges and land just after the last one.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait until the DUT is idle and every scoreboard has drained.
  task automatic wait_quiet(input string name);
    int t;
    t = 0;
    while ((cmd_q.size() != 0 || busy || exp_rsp.size() != 0 ||
            exp_wr.size() != 0 || exp_reads != 0) && t < 2000) begin
      cycles(1);
      t++;
    end
    if (t >= 2000) flag_fail({name, " timeout waiting for quiet"});
  endtask

  // Command FIFO model: a pop requested before an edge takes effect just after it.
  initial begin
    bit p;
    bus.cmd_empty = 1'b1;
    bus.cmd_data  = '0;
    forever begin
      @(negedge clk);
      p = bus.cmd_rdreq;
      @(posedge clk);
      #1;
      if (p) begin
        if (cmd_q.size() == 0) flag_fail("pop from empty command fifo");
        else begin
          void'(cmd_q.pop_front());
          pops++;
        end
      end
      bus.cmd_empty = (cmd_q.size() == 0);
      bus.cmd_data  = (cmd_q.size() == 0) ? 32'h0 : cmd_q[0];
    end
  end

  // Response monitor: every push is compared against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.rsp_wrreq) begin
        check("rsp_wrreq while full", 32'(bus.rsp_full), 32'h0);
        if (exp_rsp.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected response: got 0x%08h", bus.rsp_data);
        end else begin
          check("rsp_data", bus.rsp_data, exp_rsp.pop_front());
        end
      end
    end
  end

  // Register bus monitor: writes against the scoreboard, read strobe length.
  initial begin
    int          run;
    logic [38:0] w;
    run = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        run = 0;
      end else if (bus.reg_enable == 2'b11) begin
        if (run == 0) begin
          if (exp_reads == 0) flag_fail("unexpected read strobe");
          else exp_reads--;
        end
        run++;
      end else begin
        if (run > 0) begin
          check("read strobe length", 32'(run), 32'(RD_LAT));
          run = 0;
        end
        if (bus.reg_enable == 2'b10) begin
          if (exp_wr.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected write: addr 0x%02h data 0x%08h",
                     bus.reg_addr, bus.reg_dataout);
          end else begin
            w = exp_wr.pop_front();
            check("write addr", 32'(bus.reg_addr), 32'(w[38:32]));
            check("write data", bus.reg_dataout, w[31:0]);
          end
        end else begin
          check("reg_enable idle", 32'(bus.reg_enable), 32'h0);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    int base;
    int t;
    bus.rsp_full   = 1'b0;
    bus.reg_datain = '0;

    // Reset state.
    cycles(3);
    check("reset reg_enable", 32'(bus.reg_enable), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset err_count", 32'(err_count), 32'h0);
    check("reset rsp_wrreq", 32'(bus.rsp_wrreq), 32'h0);
    check("reset rsp_data", bus.rsp_data, 32'h0);
    reset = 1'b1;
    cycles(2);

    // 1: WRITE, two pops, no response.
    base = pops;
    exp_wr.push_back({7'h20, 32'hDEADBEEF});
    cmd_q.push_back(32'h01000020);
    cmd_q.push_back(32'hDEADBEEF);
    wait_quiet("t1");
    check("t1 pops", 32'(pops - base), 32'd2);

    // 2: READ returns header then data.
    bus.reg_datain = 32'h00001234;
    exp_reads++;
    exp_rsp.push_back(32'h825A0009);
    exp_rsp.push_back(32'h00001234);
    cmd_q.push_back(32'h025A0009);
    wait_quiet("t2");

    // 3: READ with response FIFO full while sitting in RSP_HDR.
    bus.rsp_full   = 1'b1;
    bus.reg_datain = 32'hCAFE0001;
    exp_reads++;
    exp_rsp.push_back(32'h82C30041);
    exp_rsp.push_back(32'hCAFE0001);
    cmd_q.push_back(32'h02C3FF41);
    cycles(2 + RD_LAT + 5);
    check("t3 busy while full", 32'(busy), 32'h1);
    check("t3 nothing pushed while full", 32'(exp_rsp.size()), 32'd2);
    bus.rsp_full = 1'b0;
    wait_quiet("t3");

    // 4: unknown opcodes counted, then saturation.
    cmd_q.push_back(32'h7F000000);
    cmd_q.push_back(32'h7F123456);
    cmd_q.push_back(32'h00FFFFFF);
    wait_quiet("t4a");
    check("t4 err_count 3", 32'(err_count), 32'd3);
    for (int i = 0; i < 300; i++) cmd_q.push_back(32'h7F000000 | 32'(i));
    wait_quiet("t4b");
    check("t4 err_count saturated", 32'(err_count), 32'd255);

    // 5: WRITE header, data word delayed ten cycles.
    exp_wr.push_back({7'h55, 32'h0BADF00D});
    cmd_q.push_back(32'h01AB0055);
    cycles(2);
    for (int i = 0; i < 10; i++) begin
      check("t5 busy in WDATA", 32'(busy), 32'h1);
      check("t5 reg_enable in WDATA", 32'(bus.reg_enable), 32'h0);
      cycles(1);
    end
    cmd_q.push_back(32'h0BADF00D);
    wait_quiet("t5");

    // 6: reset in the middle of a READ, then PING.
    bus.reg_datain = 32'h55AA55AA;
    exp_reads++;
    cmd_q.push_back(32'h02770011);
    t = 0;
    while (bus.reg_enable != 2'b11 && t < 20) begin
      cycles(1);
      t++;
    end
    if (t >= 20) flag_fail("t6 read strobe never seen");
    cycles(1);
    reset = 1'b0;
    cycles(1);
    check("t6 reg_enable after reset", 32'(bus.reg_enable), 32'h0);
    check("t6 busy after reset", 32'(busy), 32'h0);
    check("t6 err_count after reset", 32'(err_count), 32'h0);
    check("t6 rsp_wrreq after reset", 32'(bus.rsp_wrreq), 32'h0);
    reset = 1'b1;
    check("t6 read header consumed", 32'(cmd_q.size()), 32'd0);
    exp_rsp.push_back(32'h83110000);
    cmd_q.push_back(32'h03110000);
    wait_quiet("t6");

    // 7: mixed stream stays in order.
    bus.reg_datain = 32'h87654321;
    exp_wr.push_back({7'h7F, 32'h00000001});
    exp_reads++;
    exp_rsp.push_back(32'h82010003);
    exp_rsp.push_back(32'h87654321);
    exp_rsp.push_back(32'h83EE0000);
    cmd_q.push_back(32'h0100007F);
    cmd_q.push_back(32'h00000001);
    cmd_q.push_back(32'h02010003);
    cmd_q.push_back(32'h03EE1234);
    wait_quiet("t7");
    check("t7 err_count unchanged", 32'(err_count), 32'h0);

    cycles(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
